// File: rtl/dram_bist_pkg.sv
// Shared types and helpers for the DRAM march-style BIST block.
package dram_bist_pkg;

    // Test sequencer states; WR1/RD1 are only reachable with the inverted pass enabled.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR0  = 3'd1,
        S_RD0  = 3'd2,
        S_WR1  = 3'd3,
        S_RD1  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam int MAX_W = 16;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] ERR_MAX = 8'hFF;

    // Pattern word for an address: the address bits repeated across the word,
    // trimmed to 'width' bits, then XORed with the captured seed.
    function automatic logic [MAX_W-1:0] pat_word(
        input logic [MAX_W-1:0] addr,
        input int               addr_w,
        input int               width,
        input logic [MAX_W-1:0] seed
    );
        logic [MAX_W-1:0] amask;
        logic [MAX_W-1:0] wmask;
        logic [MAX_W-1:0] rep;
        amask = ~({MAX_W{1'b1}} << addr_w);
        wmask = ~({MAX_W{1'b1}} << width);
        rep   = '0;
        for (int s = 0; s < MAX_W; s += addr_w) begin
            rep = rep | ((addr & amask) << s);
        end
        return (rep & wmask) ^ (seed & wmask);
    endfunction

endpackage

// File: rtl/dram_bist_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, asynchronous read (LUT RAM style).
module dram_bist_ram #(
    parameter int WIDTH  = 1,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dram_bist.sv
// Memory BIST sequencer: writes a seeded address pattern, reads it back,
// optionally repeats with the inverted pattern, and reports mismatches.
// Control is a plain level protocol: start is a request sampled only in
// IDLE or DONE; busy/done/pass are levels derived from the state register.
module dram_bist
    import dram_bist_pkg::*;
#(
    parameter int  WIDTH    = 1,
    parameter int  DEPTH    = 256,
    parameter int  INV_PASS = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  seed,
    input  logic              inject_err,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output state_t            state_dbg
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  seed_q;
    logic [7:0]        err_q;
    logic [ADDR_W-1:0] first_q;

    logic              wr_phase;
    logic              rd_phase;
    logic              inv_phase;
    logic              last_addr;
    logic              start_ok;
    logic              mismatch;
    logic [WIDTH-1:0]  pat;
    logic [WIDTH-1:0]  exp_word;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  rdata;

    assign wr_phase  = (state == S_WR0) || (state == S_WR1);
    assign rd_phase  = (state == S_RD0) || (state == S_RD1);
    assign inv_phase = (state == S_WR1) || (state == S_RD1);
    assign last_addr = (addr == LAST_ADDR);
    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));

    assign pat      = WIDTH'(pat_word(MAX_W'(addr), ADDR_W, WIDTH, MAX_W'(seed_q)));
    assign exp_word = inv_phase ? ~pat : pat;
    // Fault injection flips bit 0 of the written word only.
    assign wdata    = exp_word ^ WIDTH'(inject_err);
    assign mismatch = rd_phase && (rdata != exp_word);

    dram_bist_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_phase),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: each phase walks all addresses, then hands over to the next.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_WR0;
            S_WR0:          if (last_addr) state_nxt = S_RD0;
            S_RD0:          if (last_addr) state_nxt = (INV_PASS != 0) ? S_WR1 : S_DONE;
            S_WR1:          if (last_addr) state_nxt = S_RD1;
            S_RD1:          if (last_addr) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // Address walker, seed capture and mismatch bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr    <= '0;
            seed_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
        end else if (start_ok) begin
            addr    <= '0;
            seed_q  <= seed;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            if (wr_phase || rd_phase) begin
                addr <= last_addr ? '0 : addr + ADDR_W'(1);
            end
            if (mismatch) begin
                if (err_q != ERR_MAX) begin
                    err_q <= err_q + 8'd1;
                end
                if (err_q == 8'd0) begin
                    first_q <= addr;
                end
            end
        end
    end

    assign busy           = wr_phase || rd_phase;
    assign done           = (state == S_DONE);
    assign pass           = done && (err_q == 8'd0);
    assign err_count      = err_q;
    assign first_err_addr = first_q;
    assign state_dbg      = state;

endmodule

// File: doc/dram_bist.md
DRAM_BIST -- requirements
Module: dram_bist

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the RAM data width in bits (legal 1..16).
REQ-002 The block SHALL have parameter DEPTH, default 256, giving the RAM word count (power of two, 32..1024); ADDR_W = clog2(DEPTH).
REQ-003 The block SHALL have parameter INV_PASS, default 1; when 1, a second inverted-pattern pass is run.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  begin a test run; sampled only in IDLE or DONE.
REQ-007 seed  input  WIDTH  pattern seed; captured on the start-accept edge.
REQ-008 inject_err  input  1  when high during a write cycle, bit 0 of the written word is inverted.
REQ-009 busy  output  1  high in any write or read phase.
REQ-010 done  output  1  high while in DONE.
REQ-011 pass  output  1  high in DONE when err_count == 0.
REQ-012 err_count  output  8  mismatches counted this run, saturating at 255.
REQ-013 first_err_addr  output  ADDR_W  address of the first mismatch this run; 0 if none.

Function
REQ-014 States SHALL be IDLE, WR0, RD0, WR1, RD1, DONE; WR1/RD1 exist only when INV_PASS=1.
REQ-015 start high in IDLE or DONE SHALL, at that edge, capture seed, clear err_count/first_err_addr, zero addr, and enter WR0; start in any other state SHALL be ignored.
REQ-016 Each phase SHALL visit addresses 0..DEPTH-1 in order, one per cycle, then advance: WR0->RD0->WR1->RD1->DONE (INV_PASS=0: RD0->DONE); addr wraps to 0 on each transition.
REQ-017 pat(a) SHALL be the low WIDTH bits of the address replicated to WIDTH, XOR the captured seed; WR0 writes pat(a), WR1 writes ~pat(a).
REQ-018 Read phases SHALL use the RAM's asynchronous read; compare against the expected word of the same pass in the same cycle; register the result at that edge.
REQ-019 On each mismatch err_count SHALL increment (saturating at 255); first_err_addr SHALL latch only on the mismatch that takes err_count from 0 to 1.
REQ-020 Latency: start accepted at edge k SHALL give done=1 after edge k + 2*DEPTH*(1+INV_PASS); the mismatch on the last read address SHALL be reflected in err_count at that same edge.
REQ-021 pass SHALL be combinational from done and err_count==0; pass=0 outside DONE.
REQ-022 DONE SHALL hold all outputs until rst or a new accepted start.
REQ-023 inject_err SHALL affect write cycles only; it SHALL have no effect in read, IDLE or DONE.

Reset
REQ-024 rst at any edge, including mid-phase, SHALL force IDLE, addr=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0; captured seed SHALL clear to 0.
REQ-025 RAM contents SHALL NOT be reset; reset precedes start at the same edge.

Structure
REQ-026 Shared package dram_bist_pkg SHALL hold the state enum and the pattern function.
REQ-027 Storage SHALL be a sub-module dram_bist_ram (DEPTH x WIDTH, one sync write port, async read, mapping to distributed LUT RAM).

Verification
REQ-028 WIDTH=1, DEPTH=256, INV_PASS=1, seed=0, no inject: start pulse -> done=1 exactly 1024 edges after accept, pass=1, err_count=0.
REQ-029 WIDTH=8, DEPTH=64, seed=8'hA5, inject_err high only on WR0 cycle for address 13 -> err_count=1, first_err_addr=13, pass=0.
REQ-030 inject_err held high through WR0 and WR1, DEPTH=256, WIDTH=4 -> err_count saturates at 255 (512 mismatches), first_err_addr=0.
REQ-031 rst asserted 100 cycles into RD0 -> next edge busy=0, done=0, err_count=0; a subsequent start runs a full clean pass.
REQ-032 start pulsed while busy -> ignored, completion time unchanged; start in DONE -> clean restart with cleared counters.
REQ-033 INV_PASS=0, DEPTH=32 -> done after 64 edges; state never enters WR1/RD1.
